// File: rtl/mdu_pkg.sv
// Shared op codes, FSM states and default latencies for the multiply/divide unit.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MADDU = 4'd10,
    OP_MSUB  = 4'd11,
    OP_MSUBU = 4'd12
  } mdu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  function automatic int max_cycles(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/mdu_core.sv
// Combinational datapath: maps (op, A, B, HI, LO) to the pending {HI,LO} result.
// MDU_MADD_EN adds the multiply-accumulate/subtract ops.
module mdu_core
  import mdu_pkg::*;
(
  input  mdu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] pend_hi,
  output logic [31:0] pend_lo
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;

  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'b0, a} * {32'b0, b};

  // Signed divide on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  assign a_mag = a[31] ? -a : a;
  assign b_mag = b[31] ? -b : b;
  assign q_mag = a_mag / b_mag;
  assign r_mag = a_mag % b_mag;

  always_comb begin
    pend_hi = hi;
    pend_lo = lo;
    case (op)
      OP_MULT:  {pend_hi, pend_lo} = prod_s;
      OP_MULTU: {pend_hi, pend_lo} = prod_u;
      OP_DIV: begin
        if (b != 32'd0) begin
          pend_lo = (a[31] ^ b[31]) ? -q_mag : q_mag;
          pend_hi = a[31] ? -r_mag : r_mag;
        end
      end
      OP_DIVU: begin
        if (b != 32'd0) begin
          pend_lo = a / b;
          pend_hi = a % b;
        end
      end
`ifdef MDU_MADD_EN
      OP_MADD:  {pend_hi, pend_lo} = {hi, lo} + prod_s;
      OP_MADDU: {pend_hi, pend_lo} = {hi, lo} + prod_u;
      OP_MSUB:  {pend_hi, pend_lo} = {hi, lo} - prod_s;
      OP_MSUBU: {pend_hi, pend_lo} = {hi, lo} - prod_u;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit holding HI/LO; Busy covers the op latency.
// Define MDU_MADD_EN to accept MADD/MADDU/MSUB/MSUBU.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Cancel,
  output logic        Busy,
  output logic [31:0] MDUout
);

  localparam int CNT_W = $clog2(max_cycles(MULT_CYCLES, DIV_CYCLES) + 1);

  mdu_op_e          op;
  mdu_state_e       state;
  mdu_state_e       next_state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] next_count;
  logic [31:0]      hi;
  logic [31:0]      lo;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic [31:0]      core_hi;
  logic [31:0]      core_lo;
  logic             is_mult;
  logic             is_div;
  logic             issue;
  logic             load_pend;
  logic             commit;

  assign op    = mdu_op_e'(MDUOp);
  assign issue = Start && !Cancel && (state == IDLE);

  // Without MDU_MADD_EN the accumulate codes fall through as NONE.
  always_comb begin
    is_mult = 1'b0;
    is_div  = 1'b0;
    case (op)
      OP_MULT, OP_MULTU: is_mult = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_mult = 1'b1;
`endif
      OP_DIV, OP_DIVU: is_div = 1'b1;
      default: ;
    endcase
  end

  mdu_core u_core (
    .op      (op),
    .a       (A),
    .b       (B),
    .hi      (hi),
    .lo      (lo),
    .pend_hi (core_hi),
    .pend_lo (core_lo)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= next_state;
      count <= next_count;
    end
  end

  always_comb begin
    next_state = state;
    next_count = count;
    load_pend  = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (issue && (is_mult || is_div)) begin
          next_state = RUN;
          next_count = is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
          load_pend  = 1'b1;
        end
      end
      RUN: begin
        if (count == '0) begin
          next_state = IDLE;
          commit     = 1'b1;
        end else begin
          next_count = count - CNT_W'(1);
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // The result is captured at issue, so later operand changes cannot corrupt it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else begin
      if (load_pend) begin
        pend_hi <= core_hi;
        pend_lo <= core_lo;
      end
      if (commit) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end else if (issue && op == OP_MTHI) begin
        hi <= A;
      end else if (issue && op == OP_MTLO) begin
        lo <= A;
      end
    end
  end

  assign Busy = (state == RUN);

  always_comb begin
    MDUout = '0;
    case (op)
      OP_MFHI: MDUout = hi;
      OP_MFLO: MDUout = lo;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mdu.sv
// Randomized self-checking bench for mdu against a longint arithmetic model of HI/LO.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk    = 1'b0;
  logic        reset  = 1'b0;
  logic        Start  = 1'b0;
  logic        Cancel = 1'b0;
  logic [3:0]  MDUOp  = OP_NONE;
  logic [31:0] A      = '0;
  logic [31:0] B      = '0;
  logic        Busy;
  logic [31:0] MDUout;

  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mdu dut (
    .clk    (clk),
    .reset  (reset),
    .Start  (Start),
    .MDUOp  (MDUOp),
    .A      (A),
    .B      (B),
    .Cancel (Cancel),
    .Busy   (Busy),
    .MDUout (MDUout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Architectural effect of one accepted op, from plain 64-bit arithmetic.
  function automatic void refModel(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b,
                                   inout logic [31:0] hi, inout logic [31:0] lo, output int cyc);
    longint      sa, sb, q, r;
    logic [63:0] acc, prod_s, prod_u;
    sa     = longint'($signed(a));
    sb     = longint'($signed(b));
    prod_s = sa * sb;
    prod_u = {32'b0, a} * {32'b0, b};
    acc    = {hi, lo};
    cyc    = 0;
    case (op)
      OP_MULT:  begin acc = prod_s; cyc = 5; end
      OP_MULTU: begin acc = prod_u; cyc = 5; end
      OP_DIV: begin
        cyc = 10;
        if (b != 0) begin
          q   = sa / sb;
          r   = sa % sb;
          acc = {r[31:0], q[31:0]};
        end
      end
      OP_DIVU: begin
        cyc = 10;
        if (b != 0) acc = {a % b, a / b};
      end
      OP_MTHI: acc[63:32] = a;
      OP_MTLO: acc[31:0]  = a;
`ifdef MDU_MADD_EN
      OP_MADD:  begin acc = acc + prod_s; cyc = 5; end
      OP_MADDU: begin acc = acc + prod_u; cyc = 5; end
      OP_MSUB:  begin acc = acc - prod_s; cyc = 5; end
      OP_MSUBU: begin acc = acc - prod_u; cyc = 5; end
`endif
      default: ;
    endcase
    {hi, lo} = acc;
  endfunction

  task automatic checkHiLo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    MDUOp = OP_MFHI;
    #1 checkOutput({tag, "_hi"}, MDUout, exp_hi);
    MDUOp = OP_MFLO;
    #1 checkOutput({tag, "_lo"}, MDUout, exp_lo);
    MDUOp = OP_NONE;
  endtask

  // Issue one op, measure Busy length, optionally poke Cancel/Start mid-run, then check HI/LO.
  task automatic applyStimulus(input string tag, input mdu_op_e op, input logic [31:0] a, input logic [31:0] b,
                               input bit cancel_issue, input bit cancel_mid, input bit intrude);
    logic [31:0] n_hi, n_lo;
    int          exp_cyc, cycles;
    n_hi = m_hi;
    n_lo = m_lo;
    refModel(op, a, b, n_hi, n_lo, exp_cyc);
    if (cancel_issue) begin
      n_hi = m_hi;
      n_lo = m_lo;
      exp_cyc = 0;
    end
    Start = 1'b1; MDUOp = op; A = a; B = b; Cancel = cancel_issue;
    @(posedge clk); #1;
    Start = 1'b0; MDUOp = OP_NONE; Cancel = 1'b0;
    cycles = 0;
    while (Busy === 1'b1 && cycles < 40) begin
      if (cycles == 0 && intrude) begin
        Start = 1'b1; MDUOp = OP_DIV; A = $urandom; B = 32'd3;
      end else begin
        Start = 1'b0; MDUOp = OP_NONE;
      end
      Cancel = cancel_mid;
      if (cycles == 1) begin
        MDUOp = OP_MFHI;
        #1 checkOutput({tag, "_old_hi"}, MDUout, m_hi);
        MDUOp = OP_NONE;
      end
      @(posedge clk); #1;
      cycles++;
    end
    Start = 1'b0; MDUOp = OP_NONE; Cancel = 1'b0;
    checkOutput({tag, "_busy_cycles"}, cycles, exp_cyc);
    m_hi = n_hi;
    m_lo = n_lo;
    checkHiLo(tag, m_hi, m_lo);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    mdu_op_e     rand_ops[10];
    mdu_op_e     rop;
    logic [31:0] ra, rb;
    rand_ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO,
                 OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};

    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    checkOutput("reset_busy", Busy, 1'b0);
    checkHiLo("reset", 32'h0, 32'h0);
    MDUOp = OP_NONE;
    #1 checkOutput("none_out", MDUout, 32'h0);

    applyStimulus("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, 0, 0, 0);
    checkHiLo("mult_lit", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    applyStimulus("multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3, 0, 0, 0);
    checkHiLo("multu_lit", 32'h0000_0002, 32'hFFFF_FFFA);
    applyStimulus("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
    checkHiLo("div_lit", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    applyStimulus("divu_zero", OP_DIVU, 32'd7, 32'd0, 0, 0, 0);
    checkHiLo("divu_zero_lit", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    applyStimulus("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
    checkHiLo("div_ovf_lit", 32'h0, 32'h8000_0000);
    applyStimulus("mult_cancel", OP_MULT, 32'd9, 32'd9, 1, 0, 0);
    applyStimulus("mult_cancel_mid", OP_MULT, 32'd6, 32'd7, 0, 1, 0);
    checkHiLo("mult_cancel_mid_lit", 32'h0, 32'd42);
    applyStimulus("mtlo", OP_MTLO, 32'h1234, 32'd0, 0, 0, 0);
    checkHiLo("mtlo_lit", 32'h0, 32'h1234);
    applyStimulus("div_intrude", OP_DIVU, 32'd100, 32'd7, 0, 0, 1);
    checkHiLo("div_intrude_lit", 32'd2, 32'd14);

    applyStimulus("madd_mthi", OP_MTHI, 32'h0, 32'd0, 0, 0, 0);
    applyStimulus("madd_mtlo", OP_MTLO, 32'hFFFF_FFFF, 32'd0, 0, 0, 0);
    applyStimulus("maddu", OP_MADDU, 32'd1, 32'd1, 0, 0, 0);
`ifdef MDU_MADD_EN
    checkHiLo("maddu_lit", 32'h1, 32'h0);
`else
    checkHiLo("maddu_lit", 32'h0, 32'hFFFF_FFFF);
`endif

    for (int i = 0; i < 40; i++) begin
      rop = rand_ops[$urandom_range(0, 9)];
      ra  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 20) : $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 :
            ($urandom_range(0, 4) == 0) ? 32'($signed($urandom_range(0, 10)) - 5) : $urandom;
      applyStimulus($sformatf("rand%0d", i), rop, ra, rb, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
    end

    applyStimulus("pre_reset", OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 0);
    Start = 1'b1; MDUOp = OP_DIV; A = 32'd1000; B = 32'd3;
    @(posedge clk); #1;
    Start = 1'b0; MDUOp = OP_NONE;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("midrun_reset_busy", Busy, 1'b0);
    m_hi = '0;
    m_lo = '0;
    checkHiLo("midrun_reset", 32'h0, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_reset_busy", Busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
